// File: rtl/axi_mem_arbiter.sv
`timescale 1ns/1ps
// Shares one AXI master port between an instruction-fetch unit and a load/store
// unit. One AXI transaction is in flight at a time. Contested grants alternate.
module axi_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  ifu_valid,
    output logic                  ifu_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  bus_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    state_e              state_q;
    logic                last_lsu_q;
    logic                owner_lsu_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                ifu_rvalid_q;
    logic                lsu_rvalid_q;
    logic                bus_err_q;
    logic [DATA_W-1:0]   ifu_rdata_q;
    logic [DATA_W-1:0]   lsu_rdata_q;

    logic                grant_lsu_s;
    logic                idle_s;
    logic                aw_done_s;
    logic                w_done_s;

    // LSU wins unless IFU is also asking and LSU was the one served last.
    assign grant_lsu_s = lsu_valid & (~ifu_valid | ~last_lsu_q);
    assign idle_s      = (state_q == IDLE);
    assign lsu_ready   = idle_s & grant_lsu_s;
    assign ifu_ready   = idle_s & ifu_valid & ~grant_lsu_s;

    // A channel counts as done once its valid has dropped or it handshakes now.
    assign aw_done_s   = ~awvalid_q | awready;
    assign w_done_s    = ~wvalid_q | wready;

    assign araddr      = addr_q;
    assign awaddr      = addr_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign awvalid     = awvalid_q;
    assign wvalid      = wvalid_q;
    assign bready      = bready_q;
    assign ifu_rvalid  = ifu_rvalid_q;
    assign lsu_rvalid  = lsu_rvalid_q;
    assign bus_err     = bus_err_q;
    assign ifu_rdata   = ifu_rdata_q;
    assign lsu_rdata   = lsu_rdata_q;

    // Transaction FSM with all AXI and response outputs registered.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            last_lsu_q   <= 1'b0;
            owner_lsu_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ifu_ready || lsu_ready) begin
                        owner_lsu_q <= lsu_ready;
                        last_lsu_q  <= lsu_ready;
                        if (lsu_ready) begin
                            addr_q  <= lsu_addr;
                            wdata_q <= lsu_wdata;
                            wstrb_q <= lsu_wstrb;
                        end else begin
                            addr_q  <= ifu_addr;
                            wdata_q <= '0;
                            wstrb_q <= '0;
                        end
                        if (lsu_ready && lsu_wen) begin
                            state_q   <= WR_AWW;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RD_AR;
                            arvalid_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_R;
                    end else begin
                        state_q <= RD_AR;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rready_q  <= 1'b0;
                        bus_err_q <= resp_is_err(rresp);
                        state_q   <= IDLE;
                        if (owner_lsu_q) begin
                            lsu_rvalid_q <= 1'b1;
                            lsu_rdata_q  <= rdata;
                        end else begin
                            ifu_rvalid_q <= 1'b1;
                            ifu_rdata_q  <= rdata;
                        end
                    end else begin
                        state_q <= RD_R;
                    end
                end
                WR_AWW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end else begin
                        state_q <= WR_AWW;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready_q     <= 1'b0;
                        lsu_rvalid_q <= 1'b1;
                        lsu_rdata_q  <= '0;
                        bus_err_q    <= resp_is_err(bresp);
                        state_q      <= IDLE;
                    end else begin
                        state_q <= WR_B;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for axi_mem_arbiter: a transaction-level model of requesters and
// an AXI slave with programmable stalls, checked against the DUT every cycle.
module tb_axi_mem_arbiter;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        ifu_valid = 1'b0, ifu_ready, ifu_rvalid;
    logic [31:0] ifu_addr = '0;
    logic [63:0] ifu_rdata;
    logic        lsu_valid = 1'b0, lsu_ready, lsu_wen = 1'b0, lsu_rvalid;
    logic [31:0] lsu_addr = '0;
    logic [63:0] lsu_wdata = '0, lsu_rdata;
    logic [7:0]  lsu_wstrb = '0;
    logic        bus_err;
    logic [31:0] araddr, awaddr;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [63:0] rdata = '0, wdata;
    logic [1:0]  rresp = 2'b00, bresp = 2'b00;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic [7:0]  wstrb;

    always #5 aclk = ~aclk;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .aclk(aclk), .areset(areset),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .bus_err(bus_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    req_t        ifu_q[$];
    req_t        lsu_q[$];
    int          lsu_force = 0;
    logic [31:0] lsu_force_addr = 32'h0;

    int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;

    bit          r_pend = 0, b_pend = 0, aw_seen = 0, w_seen = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
    logic [31:0] r_addr = 32'h0;

    bit          busy = 0, last_lsu_m = 0, cur_lsu = 0;
    req_t        cur;
    int          cyc = 0, acc_cyc = 0;
    logic [63:0] m_ifu_data = '0, m_lsu_data = '0;
    bit          aw_gone = 0, w_gone = 0, prev_arwait = 0, prev_awwait = 0, prev_rst = 1;

    int          n_both = 0, n_awv = 0, n_wv = 0, n_ifu_pulse = 0;
    bit          grant_log[$];
    logic [63:0] pl_data = '0;
    int          pl_lat = 0;
    bit          pl_err = 0, pl_lsu = 0;

    int          n_tests = 0, n_fail = 0;

    // Slave memory contents: a fixed boot word, otherwise derived from the address.
    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'h00000013_00000297;
        return {~a, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester and slave drivers, updated just after each rising edge.
    always @(posedge aclk) begin
        #1;
        if (ifu_q.size() > 0) begin
            ifu_valid = 1'b1;
            ifu_addr  = ifu_q[0].addr;
        end else begin
            ifu_valid = 1'b0;
            ifu_addr  = 32'h0;
        end
        if (lsu_q.size() > 0) begin
            lsu_valid = 1'b1;
            lsu_wen   = lsu_q[0].wen;
            lsu_addr  = lsu_q[0].addr;
            lsu_wdata = lsu_q[0].wdata;
            lsu_wstrb = lsu_q[0].wstrb;
        end else if (lsu_force > 0) begin
            lsu_valid = 1'b1;
            lsu_wen   = 1'b0;
            lsu_addr  = lsu_force_addr;
            lsu_force--;
        end else begin
            lsu_valid = 1'b0;
            lsu_wen   = 1'b0;
        end
        arready = arvalid && (ar_cnt >= ar_delay);
        awready = awvalid && (aw_cnt >= aw_delay);
        wready  = wvalid && (w_cnt >= w_delay);
        rvalid  = r_pend && (r_cnt >= r_delay);
        rdata   = rvalid ? mem_rd(r_addr) : 64'h0;
        rresp   = (rvalid && r_addr == err_addr) ? 2'b10 : 2'b00;
        bvalid  = b_pend;
        bresp   = 2'b00;
    end

    bit          pulse, exp_err, exp_lsu_rdy, exp_ifu_rdy, contested;
    logic [63:0] exp_data;
    int          exp_lat;

    // Model bookkeeping and per-cycle comparison, sampled mid-cycle.
    always @(negedge aclk) begin
        cyc++;
        if (areset) begin
            busy = 0; last_lsu_m = 0; m_ifu_data = '0; m_lsu_data = '0;
            r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
            aw_gone = 0; w_gone = 0; prev_arwait = 0; prev_awwait = 0;
            prev_rst = 1;
        end else begin
            if (prev_rst) begin
                chk("rst_outputs", 64'({arvalid, awvalid, wvalid, rready, bready,
                                        ifu_rvalid, lsu_rvalid, bus_err}), 64'h0);
                chk("rst_rdata", ifu_rdata | lsu_rdata, 64'h0);
            end
            prev_rst = 0;

            pulse = ifu_rvalid || lsu_rvalid;
            chk("dual_pulse", 64'(ifu_rvalid && lsu_rvalid), 64'h0);
            if (pulse) begin
                chk("pulse_expected", 64'(busy), 64'h1);
                if (busy) begin
                    exp_data = cur.wen ? 64'h0 : mem_rd(cur.addr);
                    exp_err  = !cur.wen && (cur.addr == err_addr);
                    exp_lat  = 3 + (cur.wen ? ((aw_delay > w_delay) ? aw_delay : w_delay)
                                            : ar_delay + r_delay);
                    chk("pulse_owner", 64'(lsu_rvalid), 64'(cur_lsu));
                    chk("bus_err", 64'(bus_err), 64'(exp_err));
                    chk("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
                    if (cur_lsu) m_lsu_data = exp_data;
                    else begin
                        m_ifu_data = exp_data;
                        n_ifu_pulse++;
                    end
                    pl_data = cur_lsu ? lsu_rdata : ifu_rdata;
                    pl_lat  = cyc - acc_cyc;
                    pl_err  = bus_err;
                    pl_lsu  = lsu_rvalid;
                end
                busy = 0;
            end else begin
                chk("bus_err_quiet", 64'(bus_err), 64'h0);
            end
            chk("ifu_rdata", ifu_rdata, m_ifu_data);
            chk("lsu_rdata", lsu_rdata, m_lsu_data);

            contested   = ifu_valid && lsu_valid;
            exp_lsu_rdy = !busy && (contested ? !last_lsu_m : lsu_valid);
            exp_ifu_rdy = !busy && (contested ? last_lsu_m : ifu_valid);
            chk("lsu_ready", 64'(lsu_ready), 64'(exp_lsu_rdy));
            chk("ifu_ready", 64'(ifu_ready), 64'(exp_ifu_rdy));

            if ((ifu_valid && ifu_ready) || (lsu_valid && lsu_ready)) begin
                cur_lsu = lsu_valid && lsu_ready;
                if (cur_lsu) begin
                    if (lsu_q.size() > 0) cur = lsu_q.pop_front();
                    else cur = '{wen: 1'b0, addr: lsu_force_addr, wdata: 64'h0, wstrb: 8'h0};
                end else begin
                    if (ifu_q.size() > 0) cur = ifu_q.pop_front();
                    else cur = '{wen: 1'b0, addr: ifu_addr, wdata: 64'h0, wstrb: 8'h0};
                end
                busy = 1; last_lsu_m = cur_lsu; acc_cyc = cyc;
                aw_gone = 0; w_gone = 0;
                grant_log.push_back(cur_lsu);
            end else if (busy && cyc == acc_cyc + 1) begin
                if (cur.wen) begin
                    chk("aw_first", 64'(awvalid), 64'h1);
                    chk("w_first", 64'(wvalid), 64'h1);
                end else begin
                    chk("ar_first", 64'(arvalid), 64'h1);
                end
            end

            chk("one_outstanding", 64'((arvalid || rready) && (awvalid || wvalid || bready)), 64'h0);
            if (prev_arwait) chk("ar_hold", 64'(arvalid), 64'h1);
            if (prev_awwait) chk("aw_hold", 64'(awvalid), 64'h1);
            if (arvalid) begin
                chk("araddr", 64'(araddr), 64'(cur.addr));
                chk("ar_is_read", 64'(cur.wen), 64'h0);
            end
            if (awvalid) begin
                chk("awaddr", 64'(awaddr), 64'(cur.addr));
                chk("aw_reassert", 64'(aw_gone), 64'h0);
                n_awv++;
            end
            if (wvalid) begin
                chk("wdata", wdata, cur.wdata);
                chk("wstrb", 64'(wstrb), 64'(cur.wstrb));
                chk("w_reassert", 64'(w_gone), 64'h0);
                n_wv++;
            end
            if (awvalid && wvalid) n_both++;
            prev_arwait = arvalid && !arready;
            prev_awwait = awvalid && !awready;

            if (arvalid && arready) begin r_pend = 1; r_addr = araddr; ar_cnt = 0; end
            else if (arvalid) ar_cnt++;
            if (rvalid && rready) begin r_pend = 0; r_cnt = 0; end
            else if (r_pend) r_cnt++;
            if (awvalid && awready) begin aw_seen = 1; aw_gone = 1; aw_cnt = 0; end
            else if (awvalid) aw_cnt++;
            if (wvalid && wready) begin w_seen = 1; w_gone = 1; w_cnt = 0; end
            else if (wvalid) w_cnt++;
            if (bvalid && bready) b_pend = 0;
            if (aw_seen && w_seen) begin b_pend = 1; aw_seen = 0; w_seen = 0; end
        end
    end

    task automatic wait_done(input string name, input int max_cyc);
        int k = 0;
        while ((ifu_q.size() > 0 || lsu_q.size() > 0 || busy || lsu_force > 0) && k < max_cyc) begin
            @(posedge aclk);
            k++;
        end
        if (k >= max_cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, expected completion", name, k);
        end
        repeat (2) @(posedge aclk);
    endtask

    function automatic req_t rd(input logic [31:0] a);
        return '{wen: 1'b0, addr: a, wdata: 64'h0, wstrb: 8'h0};
    endfunction

    int gl0, np0;

    initial begin
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        repeat (2) @(posedge aclk);

        // Boot fetch through an always-ready slave.
        ifu_q.push_back(rd(32'h8000_0000));
        wait_done("t1", 50);
        chk("t1_data", pl_data, 64'h00000013_00000297);
        chk("t1_latency", 64'(pl_lat), 64'd3);
        chk("t1_err", 64'(pl_err), 64'h0);
        chk("t1_owner_ifu", 64'(pl_lsu), 64'h0);

        // Load returning SLVERR.
        err_addr = 32'h8000_2000;
        lsu_q.push_back(rd(32'h8000_2000));
        wait_done("t5", 50);
        chk("t5_err", 64'(pl_err), 64'h1);
        chk("t5_data", pl_data, 64'h7FFFDFFF_80002000);
        chk("t5_owner_lsu", 64'(pl_lsu), 64'h1);

        // Store: both write channels for exactly one cycle, then zero response data.
        n_both = 0; n_awv = 0; n_wv = 0;
        lsu_q.push_back('{wen: 1'b1, addr: 32'h8000_1000, wdata: 64'hDEADBEEF_CAFEF00D, wstrb: 8'h0F});
        wait_done("t2", 50);
        chk("t2_both_cycles", 64'(n_both), 64'd1);
        chk("t2_aw_cycles", 64'(n_awv), 64'd1);
        chk("t2_lsu_rdata", lsu_rdata, 64'h0);
        chk("t2_latency", 64'(pl_lat), 64'd3);

        // Contested from reset: alternating grants starting with LSU.
        @(posedge aclk); #1 areset = 1'b1;
        grant_log.delete();
        ifu_q.push_back(rd(32'h8000_0100));
        ifu_q.push_back(rd(32'h8000_0108));
        lsu_q.push_back(rd(32'h8000_0200));
        lsu_q.push_back(rd(32'h8000_0208));
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        wait_done("t3", 100);
        chk("t3_grant_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4)
            chk("t3_grant_order", 64'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 64'b1010);

        // Stalled address channels.
        ar_delay = 4;
        ifu_q.push_back(rd(32'h8000_3000));
        wait_done("t4_read", 60);
        chk("t4_read_latency", 64'(pl_lat), 64'd7);
        ar_delay = 0; aw_delay = 2;
        n_both = 0; n_awv = 0; n_wv = 0;
        lsu_q.push_back('{wen: 1'b1, addr: 32'h8000_3100, wdata: 64'h0123_4567_89AB_CDEF, wstrb: 8'hF0});
        wait_done("t4_write", 60);
        chk("t4_w_cycles", 64'(n_wv), 64'd1);
        chk("t4_aw_cycles", 64'(n_awv), 64'd3);
        chk("t4_write_latency", 64'(pl_lat), 64'd5);
        aw_delay = 0;

        // LSU valid withdrawn while the bus is busy must never be accepted.
        ar_delay = 6;
        ifu_q.push_back(rd(32'h8000_5000));
        gl0 = grant_log.size();
        repeat (2) @(posedge aclk);
        #1 lsu_force_addr = 32'h8000_5100;
        lsu_force = 2;
        wait_done("t6", 60);
        chk("t6_accepts", 64'(grant_log.size() - gl0), 64'd1);
        chk("t6_latency", 64'(pl_lat), 64'd9);
        ar_delay = 0;

        // Reset while waiting for read data drops the transaction silently.
        r_delay = 3;
        ifu_q.push_back(rd(32'h8000_4000));
        np0 = n_ifu_pulse;
        begin
            int k = 0;
            while (!rready && k < 20) begin
                @(negedge aclk);
                k++;
            end
            chk("t7_reached_rd_r", 64'(rready), 64'h1);
        end
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        r_delay = 0;
        repeat (6) @(posedge aclk);
        chk("t7_no_pulse", 64'(n_ifu_pulse - np0), 64'd0);
        ifu_q.push_back(rd(32'h8000_0000));
        wait_done("t7_after", 50);
        chk("t7_after_pulse", 64'(n_ifu_pulse - np0), 64'd1);
        chk("t7_after_data", pl_data, 64'h00000013_00000297);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of requester and AXI address ports.
REQ-002 Parameter DATA_W, 64, data width; strobe width is DATA_W/8.
REQ-003 aclk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 areset  in  1  synchronous, active-high reset.
REQ-005 ifu_valid  in  1  instruction-fetch read request.
REQ-006 ifu_ready  out  1  IFU request accepted this cycle.
REQ-007 ifu_addr  in  ADDR_W  IFU read address.
REQ-008 ifu_rvalid  out  1  one-cycle pulse, IFU read data valid.
REQ-009 ifu_rdata  out  DATA_W  IFU read data.
REQ-010 lsu_valid  in  1  load/store request.
REQ-011 lsu_ready  out  1  LSU request accepted this cycle.
REQ-012 lsu_wen  in  1  1 = store, 0 = load.
REQ-013 lsu_addr  in  ADDR_W  LSU address.
REQ-014 lsu_wdata  in  DATA_W  store data.
REQ-015 lsu_wstrb  in  DATA_W/8  store byte strobes.
REQ-016 lsu_rvalid  out  1  one-cycle pulse, LSU load data valid or store complete.
REQ-017 lsu_rdata  out  DATA_W  load data; 0 for stores.
REQ-018 bus_err  out  1  pulses with ifu_rvalid/lsu_rvalid when the AXI response is nonzero.
REQ-019 araddr/arvalid  out  ADDR_W/1  AXI read address channel; arready  in  1.
REQ-020 rdata/rresp/rvalid  in  DATA_W/2/1  AXI read data channel; rready  out  1.
REQ-021 awaddr/awvalid  out  ADDR_W/1  AXI write address channel; awready  in  1.
REQ-022 wdata/wstrb/wvalid  out  DATA_W/DATA_W/8/1  AXI write data channel; wready  in  1.
REQ-023 bresp/bvalid  in  2/1  AXI write response channel; bready  out  1.

Function
REQ-024 FSM states SHALL be IDLE, RD_AR, RD_R, WR_AWW, WR_B; exactly one AXI transaction SHALL be outstanding at a time.
REQ-025 ifu_ready/lsu_ready SHALL be asserted only in IDLE, only for the granted requester, and only while that requester's valid is high; at most one SHALL be high per cycle.
REQ-026 Grant SHALL go to LSU when only LSU is valid and to IFU when only IFU is valid. When both are valid, grant SHALL go to the requester not served last (last_lsu flag, updated on each accept).
REQ-027 On accept, address, wen, wdata, wstrb and owner SHALL be registered. Next state is RD_AR for reads and WR_AWW for stores.
REQ-028 RD_AR: arvalid=1 and araddr=latched address, both held stable until arready; on arvalid&arready go to RD_R.
REQ-029 RD_R: rready=1; on rvalid, register rdata and rresp and go to IDLE; the owner's rvalid pulse SHALL appear the following cycle.
REQ-030 WR_AWW: awvalid and wvalid SHALL both assert in the first WR_AWW cycle. Each SHALL drop after its own handshake and never reassert within the transaction; go to WR_B once both handshakes are done, including same-cycle completion.
REQ-031 WR_B: bready=1; on bvalid go to IDLE; lsu_rvalid SHALL pulse next cycle with lsu_rdata=0.
REQ-032 Latency with always-ready slave: read accept at cycle 0, arvalid cycle 1, rvalid cycle 2, owner rvalid cycle 3; a new accept is permitted in cycle 3.
REQ-033 bus_err SHALL equal (registered rresp or bresp != 0) during the response pulse, else 0.
REQ-034 ifu_rdata/lsu_rdata SHALL hold their last value between pulses; only the owner's output updates.
REQ-035 Requester valid deasserting while not accepted SHALL cause no transaction.

Reset
REQ-036 On areset: state=IDLE; arvalid, awvalid, wvalid, rready, bready, ifu_rvalid, lsu_rvalid, bus_err = 0; rdata registers = 0; last_lsu = 0, so the first contested grant goes to LSU.
REQ-037 Reset mid-transaction SHALL abandon it without a response pulse; the first cycle after reset is IDLE.

Verification
REQ-038 IFU read 0x80000000, slave always ready returning 0x00000013_00000297 -> ifu_rvalid at cycle 3 with that data, bus_err=0.
REQ-039 LSU store addr 0x80001000, wdata 0xDEADBEEF_CAFEF00D, wstrb 0x0F -> awvalid and wvalid high together for one cycle, lsu_rvalid pulse, lsu_rdata=0.
REQ-040 IFU and LSU both valid from reset, each for 2 reads -> grants in order LSU, IFU, LSU, IFU.
REQ-041 arready held low 4 cycles, awready low 2 cycles with wready=1 -> arvalid/araddr stable throughout; wvalid drops after 1 cycle while awvalid holds.
REQ-042 rresp=2'b10 on a load -> lsu_rvalid and bus_err pulse together.
REQ-043 areset asserted in RD_R -> no ifu_rvalid, all AXI valids 0 next cycle, next request serviced normally.
